// File: rtl/instr_reg_decode.sv
// Instruction register with memory-latency wait, RISC-V field/immediate decode and fetch counter.
// Optional illegal-encoding flag enabled by defining INSTR_ILLEGAL_CHECK_EN.
module instr_reg_decode #(
    parameter int XLEN        = 64,
    parameter int MEM_LATENCY = 1
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            reset_wire,
    input  logic            LOAD_IR,
    input  logic [31:0]     mem_rdata,
    output logic [31:0]     instr,
    output logic            instr_valid,
    output logic            busy,
    output logic [6:0]      opcode,
    output logic [4:0]      rd,
    output logic [2:0]      funct3,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [6:0]      funct7,
    output logic [XLEN-1:0] imm,
    output logic            illegal,
    output logic [15:0]     fetch_count
);

    // state | meaning
    // IDLE  | no fetch since reset, instr holds NOP
    // WAIT  | counting out memory read latency
    // HOLD  | instr holds a completed capture
    typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

    localparam logic [31:0] NOP       = 32'h0000_0013;
    localparam logic [3:0]  WAIT_INIT = 4'(MEM_LATENCY - 1);

    state_t      state, state_nxt;
    logic [3:0]  wait_cnt, wait_cnt_nxt;
    logic [31:0] instr_q;
    logic        valid_q;
    logic [15:0] fetch_cnt_q;
    logic        start, capture;

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        start        = 1'b0;
        capture      = 1'b0;
        case (state)
            IDLE, HOLD: begin
                if (LOAD_IR) begin
                    state_nxt    = WAIT;
                    wait_cnt_nxt = WAIT_INIT;
                    start        = 1'b1;
                end
            end
            WAIT: begin
                // LOAD_IR is deliberately ignored here: no queuing, no restart
                if (wait_cnt != 4'd0) begin
                    wait_cnt_nxt = wait_cnt - 4'd1;
                end else begin
                    capture   = 1'b1;
                    state_nxt = HOLD;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= IDLE;
            wait_cnt    <= 4'd0;
            instr_q     <= NOP;
            valid_q     <= 1'b0;
            fetch_cnt_q <= 16'd0;
        end else if (reset_wire) begin
            state       <= IDLE;
            wait_cnt    <= 4'd0;
            instr_q     <= NOP;
            valid_q     <= 1'b0;
            fetch_cnt_q <= 16'd0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (start) begin
                valid_q <= 1'b0;
            end
            if (capture) begin
                instr_q     <= mem_rdata;
                valid_q     <= 1'b1;
                fetch_cnt_q <= fetch_cnt_q + 16'd1;
            end
        end
    end

    assign instr       = instr_q;
    assign instr_valid = valid_q;
    assign busy        = (state == WAIT);
    assign fetch_count = fetch_cnt_q;

    assign opcode = instr_q[6:0];
    assign rd     = instr_q[11:7];
    assign funct3 = instr_q[14:12];
    assign rs1    = instr_q[19:15];
    assign rs2    = instr_q[24:20];
    assign funct7 = instr_q[31:25];

    logic signed [31:0] imm32;

    always_comb begin
        imm32 = 32'sd0;
        case (instr_q[6:0])
            7'b0000011, 7'b0010011, 7'b0011011, 7'b1100111, 7'b1110011:
                imm32 = {{20{instr_q[31]}}, instr_q[31:20]};
            7'b0100011:
                imm32 = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
            7'b1100011:
                imm32 = {{19{instr_q[31]}}, instr_q[31], instr_q[7], instr_q[30:25],
                         instr_q[11:8], 1'b0};
            7'b0110111, 7'b0010111:
                imm32 = {instr_q[31:12], 12'b0};
            7'b1101111:
                imm32 = {{11{instr_q[31]}}, instr_q[31], instr_q[19:12], instr_q[20],
                         instr_q[30:21], 1'b0};
            default: imm32 = 32'sd0;
        endcase
    end

    // signed source makes the width cast sign-extend for any XLEN >= 32
    assign imm = XLEN'(imm32);

`ifdef INSTR_ILLEGAL_CHECK_EN
    logic legal_op;

    always_comb begin
        legal_op = 1'b0;
        case (instr_q[6:0])
            7'b0110011, 7'b0111011, 7'b0010011, 7'b0011011, 7'b0000011, 7'b0100011,
            7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1110011:
                legal_op = 1'b1;
            default: legal_op = 1'b0;
        endcase
    end

    assign illegal = valid_q && ((instr_q[1:0] != 2'b11) || !legal_op);
`else
    assign illegal = 1'b0;
`endif

endmodule

// File: doc/instr_reg_decode.md
Name: instr_reg_decode

Overview:
- Instruction register and field decoder directly downstream of the multicycle control FSM.
- On the controller's LOAD_IR pulse, waits out instruction-memory read latency, captures the 32-bit instruction word, and holds it stable.
- Presents decoded RISC-V fields and a sign-extended immediate to the register file, ALU and control FSM.
- Also counts fetched instructions for debug.

Parameters:
- XLEN, 64, datapath width of the imm output (32 or 64).
- MEM_LATENCY, 1, cycles from the LOAD_IR sample edge to the mem_rdata capture edge; range 1..15.

Ports:
- CLK  input  1  clock, rising edge.
- RST  input  1  asynchronous, active-high reset.
- reset_wire  input  1  synchronous clear from control FSM; same effect as RST, applied on the clock edge.
- LOAD_IR  input  1  fetch request pulse from control FSM.
- mem_rdata  input  32  instruction memory read data.
- instr  output  32  registered instruction word.
- instr_valid  output  1  instr holds a completed capture.
- busy  output  1  fetch in progress (WAIT state).
- opcode  output  7  instr[6:0].
- rd  output  5  instr[11:7].
- funct3  output  3  instr[14:12].
- rs1  output  5  instr[19:15].
- rs2  output  5  instr[24:20].
- funct7  output  7  instr[31:25].
- imm  output  XLEN  sign-extended immediate.
- illegal  output  1  unsupported encoding flag.
- fetch_count  output  16  number of captures.

Behaviour:
- Async reset and reset_wire=1 at an edge produce the same values:
  - state=IDLE, instr=32'h0000_0013 (NOP), instr_valid=0, busy=0.
  - wait counter=0, fetch_count=0, illegal=0.
- reset_wire has priority over LOAD_IR at the same edge.
- FSM states: IDLE, WAIT, HOLD.
- Transitions:
  - IDLE or HOLD with LOAD_IR=1 at edge k: go to WAIT, counter=MEM_LATENCY-1, instr_valid=0, busy=1. instr keeps its old value.
  - WAIT with counter!=0: decrement counter.
  - WAIT with counter==0: at that edge (edge k+MEM_LATENCY), instr<=mem_rdata, instr_valid=1, busy=0, fetch_count+=1, go to HOLD.
  - HOLD with LOAD_IR=0: stay; instr is frozen.
- LOAD_IR asserted while in WAIT is ignored; no queuing and no restart.
- LOAD_IR held high continuously: a new fetch starts on the edge after each capture, i.e. back-to-back fetches every MEM_LATENCY+1 cycles.
- fetch_count wraps 16'hFFFF -> 16'h0000 with no flag.
- Field outputs are combinational slices of the registered instr, so they are stable for the whole HOLD period.
- imm is combinational from instr, by opcode, sign-extended from instr[31] to XLEN:
  - I-type (0000011, 0010011, 0011011, 1100111, 1110011): instr[31:20].
  - S-type (0100011): {instr[31:25], instr[11:7]}.
  - B-type (1100011): {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}.
  - U-type (0110111, 0010111): {instr[31:12], 12'b0}.
  - J-type (1101111): {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}.
  - Any other opcode, including R-type: imm=0.
- During WAIT, field outputs reflect the previous instr. Consumers must qualify them with instr_valid.

Optional Feature:
- Macro: INSTR_ILLEGAL_CHECK_EN.
- Defined: illegal=1 when instr_valid=1 and either instr[1:0]!=2'b11 or the opcode is not in {0110011, 0111011, 0010011, 0011011, 0000011, 0100011, 1100011, 0110111, 0010111, 1101111, 1100111, 1110011}. Otherwise illegal=0, including during WAIT and after reset.
- Not defined: the port still exists and illegal is tied to 0.

Test Plan:
- Reset value: assert RST mid-WAIT -> instr=32'h00000013, instr_valid=0, busy=0, fetch_count=0, observed immediately (before the next edge).
- Basic capture: MEM_LATENCY=1, LOAD_IR pulse at edge 1, mem_rdata=32'hFFF10093 -> at edge 2: instr=32'hFFF10093, rd=1, rs1=2, imm=64'hFFFF_FFFF_FFFF_FFFF, instr_valid=1, fetch_count=1.
- Latency and ignore: MEM_LATENCY=3, LOAD_IR pulses at edges 1 and 2 -> busy high for edges 1–3, single capture at edge 4, fetch_count=1.
- Immediate formats:
  - 32'hFE000EE3 (B-type) -> imm=-4.
  - 32'h12345237 (U-type) -> imm=64'h12345000.
  - 32'h00C0006F (J-type) -> imm=12.
  - 32'h00B50023 (S-type) -> imm=0.
- Reset priority and wrap: reset_wire=1 coincident with LOAD_IR -> remains IDLE. Preload fetch_count to 16'hFFFF via 65535 fetches, then one more fetch -> fetch_count=0.
- Illegal check: with INSTR_ILLEGAL_CHECK_EN defined, capture 32'h0000007F -> illegal=1; capture 32'h00000033 -> illegal=0. Without the macro, illegal=0 for both.
